// File: rtl/traffic_pkg.sv
// Shared lamp codes, lamp classes, fault codes and state encoding
// for the traffic conflict monitor.
package traffic_pkg;

  localparam logic [6:0] CODE_GREEN  = 7'b0010000;
  localparam logic [6:0] CODE_YELLOW = 7'b0010001;
  localparam logic [6:0] CODE_RED    = 7'b0101111;
  localparam logic [6:0] CODE_BLANK  = 7'b1111111;

  typedef enum logic [1:0] {
    CLS_RED     = 2'd0,
    CLS_YELLOW  = 2'd1,
    CLS_GREEN   = 2'd2,
    CLS_INVALID = 2'd3
  } lamp_class_e;

  typedef enum logic [2:0] {
    FC_NONE       = 3'd0,
    FC_INVALID    = 3'd1,
    FC_CONFLICT   = 3'd2,
    FC_TRANSITION = 3'd3
  } fault_code_e;

  typedef enum logic [1:0] {
    ST_MONITOR = 2'd0,
    ST_PENDING = 2'd1,
    ST_FAULT   = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  function automatic logic is_active(lamp_class_e c);
    return (c == CLS_GREEN) || (c == CLS_YELLOW);
  endfunction

endpackage

// File: rtl/traffic_conflict_monitor_if.sv
// Light-code bundle between a signal controller (master) and the
// conflict monitor (slave), including the monitor's lamp drive and status.
interface traffic_conflict_monitor_if;
  logic [6:0] WTL;
  logic [6:0] ETL;
  logic [6:0] NLTL;
  logic [6:0] ELTL;
  logic       fault_clr;
  logic [6:0] mon_WTL;
  logic [6:0] mon_ETL;
  logic [6:0] mon_NLTL;
  logic [6:0] mon_ELTL;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] fault_count;

  modport master (
    output WTL, ETL, NLTL, ELTL, fault_clr,
    input  mon_WTL, mon_ETL, mon_NLTL, mon_ELTL, fault, fault_code, fault_count
  );

  modport slave (
    input  WTL, ETL, NLTL, ELTL, fault_clr,
    output mon_WTL, mon_ETL, mon_NLTL, mon_ELTL, fault, fault_code, fault_count
  );
endinterface

// File: rtl/traffic_conflict_monitor_light_decode.sv
// Classifies one 7-bit lamp code as RED, YELLOW, GREEN or INVALID.
module light_decode
  import traffic_pkg::*;
(
  input  logic [6:0]  code_i,
  output lamp_class_e class_o
);

  always_comb begin
    class_o = CLS_INVALID;
    case (code_i)
      CODE_GREEN:  class_o = CLS_GREEN;
      CODE_YELLOW: class_o = CLS_YELLOW;
      CODE_RED:    class_o = CLS_RED;
      default:     class_o = CLS_INVALID;
    endcase
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Watches four approach lamp codes for conflicts, bad codes and illegal
// sequencing; on a latched fault it flashes the lamps until an operator clear.
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE   = 2,
  parameter int unsigned FLASH_HALF = 4,
  parameter int unsigned CLR_ALLRED = 3
) (
  input  logic clk,
  input  logic sys_reset,
  traffic_conflict_monitor_if.slave bus
);

  // Lamp index order: 0=W, 1=E, 2=NL, 3=EL
  logic [6:0]  light [4];
  lamp_class_e cls   [4];

  state_e      state_q;
  logic [6:0]  prev_q [4];
  logic [6:0]  mon_q  [4];
  logic [3:0]  deb_cnt_q;
  logic [3:0]  allred_cnt_q;
  logic [7:0]  flash_cnt_q;
  logic        flash_lit_q;
  logic        fault_q;
  fault_code_e fault_code_q;
  logic [7:0]  fault_count_q;

  logic        any_invalid, conflict, illegal, all_red, cond, enter_fault;
  logic        flash_lit_d;
  logic [7:0]  flash_cnt_d;
  fault_code_e latch_code;

  assign light[0] = bus.WTL;
  assign light[1] = bus.ETL;
  assign light[2] = bus.NLTL;
  assign light[3] = bus.ELTL;

  for (genvar g = 0; g < 4; g++) begin : g_decode
    light_decode u_decode (.code_i(light[g]), .class_o(cls[g]));
  end

  always_comb begin
    any_invalid = 1'b0;
    illegal     = 1'b0;
    all_red     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (cls[i] == CLS_INVALID) any_invalid = 1'b1;
      if (cls[i] != CLS_RED) all_red = 1'b0;
      if (((prev_q[i] == CODE_GREEN) && (cls[i] == CLS_RED)) ||
          ((prev_q[i] == CODE_RED) && (cls[i] == CLS_YELLOW))) illegal = 1'b1;
    end
    // W+E and E+NL are compatible movements and deliberately absent here
    conflict = (is_active(cls[0]) && is_active(cls[2])) ||
               (is_active(cls[0]) && is_active(cls[3])) ||
               (is_active(cls[1]) && is_active(cls[3])) ||
               (is_active(cls[2]) && is_active(cls[3]));
    cond = any_invalid || conflict;
    latch_code = any_invalid ? FC_INVALID : (conflict ? FC_CONFLICT : FC_TRANSITION);

    enter_fault = 1'b0;
    if (state_q == ST_MONITOR)
      enter_fault = illegal || (cond && (DEBOUNCE == 1));
    else if (state_q == ST_PENDING)
      enter_fault = illegal || (cond && (({1'b0, deb_cnt_q} + 5'd1) >= 5'(DEBOUNCE)));

    if (flash_cnt_q == 8'(FLASH_HALF - 1)) begin
      flash_cnt_d = 8'd0;
      flash_lit_d = ~flash_lit_q;
    end else begin
      flash_cnt_d = flash_cnt_q + 8'd1;
      flash_lit_d = flash_lit_q;
    end
  end

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q       <= ST_MONITOR;
      deb_cnt_q     <= 4'd0;
      allred_cnt_q  <= 4'd0;
      flash_cnt_q   <= 8'd0;
      flash_lit_q   <= 1'b0;
      fault_q       <= 1'b0;
      fault_code_q  <= FC_NONE;
      fault_count_q <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        prev_q[i] <= CODE_RED;
        mon_q[i]  <= CODE_RED;
      end
    end else begin
      for (int i = 0; i < 4; i++) prev_q[i] <= light[i];
      if (enter_fault) begin
        state_q      <= ST_FAULT;
        fault_q      <= 1'b1;
        fault_code_q <= latch_code;
        deb_cnt_q    <= 4'd0;
        if (fault_count_q != 8'hFF) fault_count_q <= fault_count_q + 8'd1;
        flash_cnt_q  <= 8'd0;
        flash_lit_q  <= 1'b1;
        mon_q[0]     <= CODE_YELLOW;
        mon_q[1]     <= CODE_YELLOW;
        mon_q[2]     <= CODE_RED;
        mon_q[3]     <= CODE_RED;
      end else begin
        case (state_q)
          ST_MONITOR: begin
            if (cond) begin
              state_q   <= ST_PENDING;
              deb_cnt_q <= 4'd1;
            end
            for (int i = 0; i < 4; i++) mon_q[i] <= light[i];
          end
          ST_PENDING: begin
            if (cond) begin
              deb_cnt_q <= deb_cnt_q + 4'd1;
            end else begin
              state_q   <= ST_MONITOR;
              deb_cnt_q <= 4'd0;
            end
            for (int i = 0; i < 4; i++) mon_q[i] <= light[i];
          end
          default: begin
            // FAULT and RECOVER share the free-running flash phase
            flash_cnt_q <= flash_cnt_d;
            flash_lit_q <= flash_lit_d;
            mon_q[0]    <= flash_lit_d ? CODE_YELLOW : CODE_BLANK;
            mon_q[1]    <= flash_lit_d ? CODE_YELLOW : CODE_BLANK;
            mon_q[2]    <= flash_lit_d ? CODE_RED : CODE_BLANK;
            mon_q[3]    <= flash_lit_d ? CODE_RED : CODE_BLANK;
            if (state_q == ST_FAULT) begin
              if (bus.fault_clr) begin
                state_q      <= ST_RECOVER;
                allred_cnt_q <= 4'd0;
              end
            end else if (!all_red) begin
              allred_cnt_q <= 4'd0;
            end else if ((allred_cnt_q + 4'd1) == 4'(CLR_ALLRED)) begin
              state_q      <= ST_MONITOR;
              allred_cnt_q <= 4'd0;
              fault_q      <= 1'b0;
              fault_code_q <= FC_NONE;
              for (int i = 0; i < 4; i++) mon_q[i] <= light[i];
            end else begin
              allred_cnt_q <= allred_cnt_q + 4'd1;
            end
          end
        endcase
      end
    end
  end

  assign bus.mon_WTL     = mon_q[0];
  assign bus.mon_ETL     = mon_q[1];
  assign bus.mon_NLTL    = mon_q[2];
  assign bus.mon_ELTL    = mon_q[3];
  assign bus.fault       = fault_q;
  assign bus.fault_code  = fault_code_q;
  assign bus.fault_count = fault_count_q;

endmodule
